// File: rtl/softmax_row_sum_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : softmax_row_sum_scheduler
// Description : Issues rows to the 64-lane pipelined tree-sum accumulator.
//               Each issued row is tagged, and the tag is paired with the sum
//               that returns ACC_LAT cycles later. Paired results are buffered
//               behind a valid/ready port. The accumulator cannot stall, so
//               row admission is limited by credit. An optional stall-cycle
//               counter is enabled by defining SCHED_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module softmax_row_sum_scheduler #(
    parameter int SUM_W     = 24,
    parameter int ID_W      = 6,
    parameter int RES_DEPTH = 8,
    parameter int ACC_LAT   = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             row_valid,
    output logic             row_ready,
    input  logic [ID_W-1:0]  row_id,
    input  logic             row_last,
    output logic             acc_start,
    input  logic [SUM_W-1:0] acc_sum_in,
    input  logic             acc_sum_valid,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [SUM_W-1:0] res_sum,
    output logic [ID_W-1:0]  res_id,
    output logic             res_last,
    output logic             done,
    output logic             busy,
`ifdef SCHED_STALL_CNT_EN
    output logic [31:0]      stall_cnt,
`endif
    output logic             err_protocol
);

    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int OCC_W = $clog2(RES_DEPTH) + 1;

    localparam logic [OCC_W-1:0] c_depth   = OCC_W'(RES_DEPTH);
    localparam logic [OCC_W-1:0] c_occ_one = OCC_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    // Control state
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_out_en;      // low for the first cycle after reset so all outputs read 0
    logic [OCC_W-1:0]   r_occ;         // rows in flight plus results buffered
    logic [OCC_W-1:0]   w_occ_nxt;
    logic [ACC_LAT-1:0] r_exp;         // one bit per issued row, travelling with the accumulator
    logic [ACC_LAT-1:0] w_exp_nxt;
    logic               r_err;

    // Tag FIFO: rows issued but not yet returned
    logic [ID_W-1:0]      r_tag_id [RES_DEPTH];
    logic [RES_DEPTH-1:0] r_tag_last;
    logic [PTR_W-1:0]     r_tag_wp;
    logic [PTR_W-1:0]     r_tag_rp;

    // Result FIFO
    logic [SUM_W-1:0]     r_res_sum [RES_DEPTH];
    logic [ID_W-1:0]      r_res_id  [RES_DEPTH];
    logic [RES_DEPTH-1:0] r_res_last;
    logic [PTR_W-1:0]     r_res_wp;
    logic [PTR_W-1:0]     r_res_rp;
    logic [OCC_W-1:0]     r_res_cnt;

    // Datapath / handshake wires
    logic w_tail;
    logic w_ret_ok;
    logic w_res_pop;
    logic w_res_full;
    logic w_res_push;
    logic w_lost;
    logic w_err_evt;
    logic w_head_last;

    // Admission and issue
    assign row_ready = r_out_en & (r_state != c_st_drain) & (r_occ < c_depth);
    assign acc_start = row_valid & row_ready;

    // Return pairing: the expect-shift tail marks the cycle a sum is due
    assign w_tail     = r_exp[ACC_LAT-1];
    assign w_ret_ok   = w_tail & acc_sum_valid;
    assign w_res_pop  = res_valid & res_ready;
    assign w_res_full = (r_res_cnt == c_depth);
    // A full buffer still accepts a write when its head leaves in the same cycle
    assign w_res_push = w_ret_ok & (~w_res_full | w_res_pop);
    // A due row that produces no buffered result gives its credit back here
    assign w_lost     = w_tail & ~w_res_push;
    assign w_err_evt  = (acc_sum_valid & ~w_tail)
                      | (w_tail & ~acc_sum_valid)
                      | (w_ret_ok & ~w_res_push);

    // Output port
    assign res_valid    = (r_res_cnt != '0);
    assign w_head_last  = r_res_last[r_res_rp];
    assign res_sum      = res_valid ? r_res_sum[r_res_rp] : '0;
    assign res_id       = res_valid ? r_res_id[r_res_rp]  : '0;
    assign res_last     = res_valid & w_head_last;
    assign done         = (r_state == c_st_drain) & w_res_pop & w_head_last;
    assign busy         = (r_state != c_st_idle);
    assign err_protocol = r_err;

    assign w_occ_nxt = r_occ
                     + (acc_start ? c_occ_one : '0)
                     - (w_res_pop ? c_occ_one : '0)
                     - (w_lost    ? c_occ_one : '0);

    generate
        if (ACC_LAT == 1) begin : g_exp_lat1
            assign w_exp_nxt = acc_start;
        end else begin : g_exp_latn
            assign w_exp_nxt = {r_exp[ACC_LAT-2:0], acc_start};
        end
    endgenerate

    // Next-state logic: IDLE -> RUN -> DRAIN -> IDLE, skipping RUN for a single-row matrix
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (acc_start) begin
                    w_state_nxt = row_last ? c_st_drain : c_st_run;
                end
            end
            c_st_run: begin
                if (acc_start && row_last) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                if (done) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Control registers: state, credit count, expect-shift and sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_out_en <= 1'b0;
            r_occ    <= '0;
            r_exp    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_out_en <= 1'b1;
            r_occ    <= w_occ_nxt;
            r_exp    <= w_exp_nxt;
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
        end
    end

    // Tag FIFO pointers: push on issue, pop whenever a sum is due
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag_wp <= '0;
            r_tag_rp <= '0;
        end else begin
            if (acc_start) begin
                r_tag_wp <= r_tag_wp + c_ptr_one;
            end
            if (w_tail) begin
                r_tag_rp <= r_tag_rp + c_ptr_one;
            end
        end
    end

    // Tag FIFO storage
    always_ff @(posedge clk) begin
        if (acc_start) begin
            r_tag_id[r_tag_wp]   <= row_id;
            r_tag_last[r_tag_wp] <= row_last;
        end
    end

    // Result FIFO pointers and fill count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res_wp  <= '0;
            r_res_rp  <= '0;
            r_res_cnt <= '0;
        end else begin
            if (w_res_push) begin
                r_res_wp <= r_res_wp + c_ptr_one;
            end
            if (w_res_pop) begin
                r_res_rp <= r_res_rp + c_ptr_one;
            end
            if (w_res_push && !w_res_pop) begin
                r_res_cnt <= r_res_cnt + c_occ_one;
            end else if (!w_res_push && w_res_pop) begin
                r_res_cnt <= r_res_cnt - c_occ_one;
            end
        end
    end

    // Result FIFO storage: returned sum joined with the oldest outstanding tag
    always_ff @(posedge clk) begin
        if (w_res_push) begin
            r_res_sum[r_res_wp]  <= acc_sum_in;
            r_res_id[r_res_wp]   <= r_tag_id[r_tag_rp];
            r_res_last[r_res_wp] <= r_tag_last[r_tag_rp];
        end
    end

`ifdef SCHED_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of cycles a row waited for admission
    always_ff @(posedge clk) begin
        if (!rst_n || done) begin
            r_stall_cnt <= '0;
        end else if (row_valid && !row_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_softmax_row_sum_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_softmax_row_sum_scheduler
// Description : Bench for softmax_row_sum_scheduler with an accumulator
//               emulator and a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_softmax_row_sum_scheduler;

    localparam int SUM_W = 24;
    localparam int ID_W  = 6;
    localparam int DEPTH = 8;
    localparam int LAT   = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             row_valid;
    logic             row_ready;
    logic [ID_W-1:0]  row_id;
    logic             row_last;
    logic             acc_start;
    logic [SUM_W-1:0] acc_sum_in;
    logic             acc_sum_valid;
    logic             res_valid;
    logic             res_ready;
    logic [SUM_W-1:0] res_sum;
    logic [ID_W-1:0]  res_id;
    logic             res_last;
    logic             done;
    logic             busy;
    logic             err_protocol;
`ifdef SCHED_STALL_CNT_EN
    logic [31:0]      stall_cnt;
    logic [31:0]      m_stall;
`endif

    always #5 clk = ~clk;

    softmax_row_sum_scheduler #(
        .SUM_W(SUM_W), .ID_W(ID_W), .RES_DEPTH(DEPTH), .ACC_LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .row_valid(row_valid), .row_ready(row_ready), .row_id(row_id), .row_last(row_last),
        .acc_start(acc_start), .acc_sum_in(acc_sum_in), .acc_sum_valid(acc_sum_valid),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_id(res_id),
        .res_last(res_last), .done(done), .busy(busy),
`ifdef SCHED_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .err_protocol(err_protocol)
    );

    typedef struct {
        logic [ID_W-1:0]  id;
        logic             last;
        logic [SUM_W-1:0] sum;
        int               rdy;
    } row_t;

    typedef struct {
        logic [ID_W-1:0]  id;
        logic [SUM_W-1:0] sum;
        int               lat;
    } vec_t;

    // Reference model: rows accepted but not yet consumed, oldest first
    row_t m_q[$];
    bit   m_en, m_drain, m_busy, m_err;

    // Accumulator emulator: fixed LAT-cycle delay line
    logic             emu_v [LAT];
    logic [SUM_W-1:0] emu_s [LAT];

    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    bit  chk_en;
    bit  inj_spur;
    logic [SUM_W-1:0] next_sum;

    // Values sampled mid-cycle by step()
    bit s_start, s_ready, s_rvalid, s_done, s_busy, s_err, s_last;
    logic [ID_W-1:0]  s_id;
    logic [SUM_W-1:0] s_sum;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: present emulator output, sample, check model, advance model
    task automatic step();
        row_t r;
        bit exp_ready, exp_rv, exp_done, hs, acc;
        acc_sum_valid = emu_v[LAT-1] | inj_spur;
        acc_sum_in    = emu_v[LAT-1] ? emu_s[LAT-1] : (inj_spur ? 24'h5A5A5A : '0);
        #1;
        s_start = acc_start; s_ready = row_ready; s_rvalid = res_valid; s_done = done;
        s_busy = busy; s_err = err_protocol; s_id = res_id; s_sum = res_sum; s_last = res_last;

        exp_ready = m_en && !m_drain && (m_q.size() < DEPTH);
        exp_rv    = (m_q.size() > 0) && (m_q[0].rdy <= cyc);
        exp_done  = exp_rv && res_ready && m_q[0].last;
        if (chk_en) begin
            chk("row_ready", 32'(row_ready), 32'(exp_ready));
            chk("acc_start", 32'(acc_start), 32'(row_valid && exp_ready));
            chk("res_valid", 32'(res_valid), 32'(exp_rv));
            chk("done", 32'(done), 32'(exp_done));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("err_protocol", 32'(err_protocol), 32'(m_err));
            if (exp_rv) begin
                chk("res_id", 32'(res_id), 32'(m_q[0].id));
                chk("res_sum", 32'(res_sum), 32'(m_q[0].sum));
                chk("res_last", 32'(res_last), 32'(m_q[0].last));
            end
`ifdef SCHED_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, m_stall);
`endif
        end

        hs  = exp_rv && res_ready;
        acc = row_valid && exp_ready;
        if (!rst_n) begin
            m_q.delete();
            m_drain = 0; m_busy = 0; m_err = 0;
            for (int k = 0; k < LAT; k++) begin emu_v[k] = 1'b0; emu_s[k] = '0; end
`ifdef SCHED_STALL_CNT_EN
            m_stall = 0;
`endif
        end else begin
`ifdef SCHED_STALL_CNT_EN
            if (exp_done) m_stall = 0;
            else if (row_valid && !exp_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
`endif
            if (hs) begin
                if (m_q[0].last) begin m_drain = 0; m_busy = 0; end
                void'(m_q.pop_front());
            end
            if (acc) begin
                r.id = row_id; r.last = row_last; r.sum = next_sum; r.rdy = cyc + LAT + 1;
                m_q.push_back(r);
                m_busy = 1;
                if (row_last) m_drain = 1;
            end
            if (inj_spur) m_err = 1;
            for (int k = LAT - 1; k > 0; k--) begin emu_v[k] = emu_v[k-1]; emu_s[k] = emu_s[k-1]; end
            emu_v[0] = acc_start;
            emu_s[0] = next_sum;
        end
        m_en = rst_n;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        int   t0, lat, extra, n_acc, cnt, n_hs;
        bit   found;
        logic [ID_W-1:0] got[$];

        tbl[0] = '{id: 6'd5,  sum: 24'h000400, lat: 8};
        tbl[1] = '{id: 6'd63, sum: 24'hFFFFFF, lat: 8};
        tbl[2] = '{id: 6'd0,  sum: 24'h000000, lat: 8};
        tbl[3] = '{id: 6'd42, sum: 24'h123456, lat: 8};

        rst_n = 0; row_valid = 0; row_id = '0; row_last = 0; res_ready = 0;
        inj_spur = 0; next_sum = '0; acc_sum_valid = 0; acc_sum_in = '0;
        m_en = 0; m_drain = 0; m_busy = 0; m_err = 0; chk_en = 0;
`ifdef SCHED_STALL_CNT_EN
        m_stall = 0;
`endif
        for (int k = 0; k < LAT; k++) begin emu_v[k] = 1'b0; emu_s[k] = '0; end
        #1;
        step();
        chk_en = 1;
        step();
        step();

        // Reset state: all outputs low in the first cycle after reset, then ready
        rst_n = 1;
        step();
        chk("rst_row_ready", 32'(s_ready), 32'd0);
        chk("rst_res_valid", 32'(s_rvalid), 32'd0);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_err", 32'(s_err), 32'd0);
        step();
        chk("post_rst_row_ready", 32'(s_ready), 32'd1);

        // Single-row matrices from the table
        for (int i = 0; i < 4; i++) begin
            row_valid = 1; row_id = tbl[i].id; row_last = 1; next_sum = tbl[i].sum; res_ready = 1;
            step();
            chk("single_acc_start", 32'(s_start), 32'd1);
            t0 = cyc - 1;
            row_valid = 0; row_last = 0;
            found = 0; extra = 0; lat = 0;
            for (int w = 0; w < 20 && !found; w++) begin
                step();
                if (s_start) extra++;
                if (s_rvalid) begin
                    found = 1;
                    lat = (cyc - 1) - t0;
                    chk("single_id", 32'(s_id), 32'(tbl[i].id));
                    chk("single_sum", 32'(s_sum), 32'(tbl[i].sum));
                    chk("single_done", 32'(s_done), 32'd1);
                end
            end
            chk("single_seen", 32'(found), 32'd1);
            chk("single_latency", 32'(lat), 32'(tbl[i].lat));
            chk("single_extra_start", 32'(extra), 32'd0);
            step();
            chk("single_idle", 32'(s_busy), 32'd0);
        end

        // Back-to-back rows against a stalled consumer: credit runs out at 8
        res_ready = 0; row_last = 0; row_valid = 1; n_acc = 0;
        for (int k = 0; k < 12; k++) begin
            row_id = 6'(n_acc); next_sum = 24'(32'h1000 + n_acc);
            step();
            if (s_start) n_acc++;
        end
        chk("bp_accepts", 32'(n_acc), 32'd8);
        chk("bp_ready_low", 32'(s_ready), 32'd0);
        row_id = 6'd8; row_last = 1; next_sum = 24'h00ABCD; extra = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (s_start) extra++;
        end
        chk("bp_no_9th_start", 32'(extra), 32'd0);
        res_ready = 1;
        got.delete();
        step();
        if (s_rvalid) got.push_back(s_id);
        chk("bp_first_pop_ready", 32'(s_ready), 32'd0);
        step();
        if (s_rvalid) got.push_back(s_id);
        chk("bp_ready_after_pop", 32'(s_ready), 32'd1);
        chk("bp_9th_start", 32'(s_start), 32'd1);
        row_valid = 0; row_last = 0;
        found = 0;
        for (int w = 0; w < 40 && !found; w++) begin
            step();
            if (s_rvalid) got.push_back(s_id);
            if (s_done) found = 1;
        end
        chk("bp_done_seen", 32'(found), 32'd1);
        chk("bp_result_count", 32'(got.size()), 32'd9);
        for (int k = 0; k < got.size() && k < 9; k++) chk("bp_order", 32'(got[k]), 32'(k));
        step();

        // Spurious accumulator return with nothing in flight
        inj_spur = 1;
        step();
        inj_spur = 0;
        step();
        chk("spur_err", 32'(s_err), 32'd1);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (s_rvalid) cnt++;
        end
        chk("spur_no_result", 32'(cnt), 32'd0);
        chk("spur_sticky", 32'(s_err), 32'd1);
        rst_n = 0;
        step();
        rst_n = 1;
        step();
        chk("spur_err_cleared", 32'(s_err), 32'd0);

        // Reset with three rows in flight
        res_ready = 1; row_valid = 1; row_last = 0; n_acc = 0;
        for (int k = 0; k < 3; k++) begin
            row_id = 6'(10 + k); next_sum = 24'(32'h2000 + k);
            step();
            if (s_start) n_acc++;
        end
        chk("mid_rst_accepts", 32'(n_acc), 32'd3);
        row_valid = 0;
        step();
        rst_n = 0;
        step();
        rst_n = 1;
        step();
        chk("mid_rst_ready", 32'(s_ready), 32'd0);
        chk("mid_rst_busy", 32'(s_busy), 32'd0);
        chk("mid_rst_res_valid", 32'(s_rvalid), 32'd0);
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (s_rvalid) cnt++;
        end
        chk("mid_rst_no_results", 32'(cnt), 32'd0);

        // Last flag on row 3: no admission in DRAIN even with credit left
        res_ready = 0; row_valid = 1;
        for (int k = 0; k < 4; k++) begin
            row_id = 6'(k); row_last = (k == 3); next_sum = 24'(32'h3000 + k);
            step();
            chk("drain_accept", 32'(s_start), 32'd1);
        end
        row_id = 6'd4; row_last = 0; cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (s_ready) cnt++;
        end
        chk("drain_no_ready", 32'(cnt), 32'd0);
        row_valid = 0; res_ready = 1; found = 0; n_hs = 0;
        for (int w = 0; w < 40 && !found; w++) begin
            step();
            if (s_rvalid) n_hs++;
            if (s_done) begin
                found = 1;
                chk("drain_done_id", 32'(s_id), 32'd3);
            end
        end
        chk("drain_done_seen", 32'(found), 32'd1);
        chk("drain_results", 32'(n_hs), 32'd4);
        step();
        chk("drain_idle", 32'(s_busy), 32'd0);
        chk("drain_idle_ready", 32'(s_ready), 32'd1);

        // Randomized matrices checked by the model inside step()
        for (int m = 0; m < 6; m++) begin
            int nrows, issued;
            nrows = $urandom_range(1, 14);
            issued = 0; found = 0;
            for (int w = 0; w < 400 && !found; w++) begin
                row_valid = (issued < nrows) && ($urandom_range(0, 99) < 70);
                row_id    = 6'($urandom);
                row_last  = (issued == nrows - 1);
                next_sum  = 24'($urandom);
                res_ready = ($urandom_range(0, 99) < 60);
                step();
                if (s_start) issued++;
                if (s_done) found = 1;
            end
            chk("rand_done_seen", 32'(found), 32'd1);
            row_valid = 0; row_last = 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
